// File: rtl/ltc_pkg.sv
// Shared widths and lock-state encoding for the local time counter keeper.
package ltc_pkg;

   localparam int unsigned LTC_W   = 48;
   localparam int unsigned DELTA_W = 32;
   localparam int unsigned CNT_W   = 16;

   typedef enum logic [1:0] {
      StUnlocked = 2'd0,
      StAcquire  = 2'd1,
      StLocked   = 2'd2
   } ltc_state_e;

endpackage

// File: rtl/ltc_keeper_if.sv
// Load stream, statistics clear and firmware-visible LTC/statistics outputs.
interface ltc_keeper_if;
   import ltc_pkg::*;

   logic               ltc_wr_req;
   logic [LTC_W-1:0]   ltc_wr_data;
   logic               stat_clr;
   logic [LTC_W-1:0]   ltc;
   logic [CNT_W-1:0]   load_cnt;
   logic [CNT_W-1:0]   slip_cnt;
   logic [DELTA_W-1:0] last_delta;
   logic [DELTA_W-1:0] max_abs_delta;
   logic               delta_sat;
   logic               locked;

   // Time-transfer side: issues loads and clears, observes the counter.
   modport master (
      output ltc_wr_req, ltc_wr_data, stat_clr,
      input  ltc, load_cnt, slip_cnt, last_delta, max_abs_delta, delta_sat, locked
   );

   // Keeper side.
   modport slave (
      input  ltc_wr_req, ltc_wr_data, stat_clr,
      output ltc, load_cnt, slip_cnt, last_delta, max_abs_delta, delta_sat, locked
   );

endinterface

// File: rtl/ltc_delta_calc.sv
// Combinational correction measurement for one load: signed delta between the
// compensated load value and the value the counter would have reached, plus
// saturated 32-bit views of delta and |delta| and the slip decision.
module ltc_delta_calc
   import ltc_pkg::*;
#(
   parameter int unsigned LOAD_OFFSET = 1,
   parameter int unsigned SLIP_TOL    = 0
) (
   input  logic [LTC_W-1:0]   ltc,
   input  logic [LTC_W-1:0]   wr_data,
   output logic [DELTA_W-1:0] delta,
   output logic [DELTA_W-1:0] abs_delta,
   output logic               sat,
   output logic               slip
);

   localparam logic [LTC_W-1:0] OFS = LTC_W'(LOAD_OFFSET);

   logic [LTC_W-1:0] d_raw;
   logic [LTC_W-1:0] d_abs;
   logic             pos_ovf;
   logic             neg_ovf;

   // Delta is taken mod 2^48 and read as signed; |delta| stays unsigned so that
   // -2^47 maps to 2^47 and saturates like any other large magnitude.
   always_comb begin
      d_raw   = (wr_data + OFS) - (ltc + LTC_W'(1));
      d_abs   = d_raw[LTC_W-1] ? (LTC_W'(0) - d_raw) : d_raw;
      pos_ovf = !d_raw[LTC_W-1] && (d_raw[LTC_W-2:DELTA_W-1] != '0);
      neg_ovf = d_raw[LTC_W-1] && !(&d_raw[LTC_W-2:DELTA_W-1]);
      sat     = pos_ovf || neg_ovf;
      if (pos_ovf) begin
         delta = {1'b0, {(DELTA_W-1){1'b1}}};
      end else if (neg_ovf) begin
         delta = {1'b1, {(DELTA_W-1){1'b0}}};
      end else begin
         delta = d_raw[DELTA_W-1:0];
      end
      if (d_abs[LTC_W-1:DELTA_W-1] != '0) begin
         abs_delta = {1'b0, {(DELTA_W-1){1'b1}}};
      end else begin
         abs_delta = d_abs[DELTA_W-1:0];
      end
      slip = d_abs > LTC_W'(SLIP_TOL);
   end

endmodule

// File: rtl/ltc_keeper.sv
// Local time counter: free-runs, reloads with latency compensation, measures
// each correction and tracks lock with a holdover timeout.
module ltc_keeper
   import ltc_pkg::*;
#(
   parameter int unsigned LOAD_OFFSET  = 1,
   parameter int unsigned SLIP_TOL     = 0,
   parameter int unsigned STABLE_CNT   = 4,
   parameter int unsigned HOLDOVER_CYC = 240000000
) (
   input logic         clk,
   input logic         rst_n,
   ltc_keeper_if.slave bus
);

   localparam logic [LTC_W-1:0] OFS        = LTC_W'(LOAD_OFFSET);
   localparam logic [7:0]       STABLE_LIM = 8'(STABLE_CNT);
   // The transition fires on the cycle whose increment would reach the limit.
   localparam logic [31:0]      HOLD_LAST  = 32'(HOLDOVER_CYC - 1);

   ltc_state_e         state_q, state_d;
   logic [7:0]         good_q, good_d;
   logic [31:0]        idle_q, idle_d;
   logic [LTC_W-1:0]   ltc_q, ltc_d;
   logic [CNT_W-1:0]   load_cnt_q, load_cnt_d;
   logic [CNT_W-1:0]   slip_cnt_q, slip_cnt_d;
   logic [DELTA_W-1:0] last_delta_q, last_delta_d;
   logic [DELTA_W-1:0] max_abs_q, max_abs_d;
   logic               sat_q, sat_d;

   logic [DELTA_W-1:0] calc_delta;
   logic [DELTA_W-1:0] calc_abs;
   logic               calc_sat;
   logic               calc_slip;
   logic               evaluate;

   ltc_delta_calc #(
      .LOAD_OFFSET (LOAD_OFFSET),
      .SLIP_TOL    (SLIP_TOL)
   ) u_delta_calc (
      .ltc       (ltc_q),
      .wr_data   (bus.ltc_wr_data),
      .delta     (calc_delta),
      .abs_delta (calc_abs),
      .sat       (calc_sat),
      .slip      (calc_slip)
   );

   // The first load after losing lock only aligns the counter; it is not measured.
   assign evaluate = bus.ltc_wr_req && (state_q != StUnlocked);

   // Counter next value: compensated load or free-run increment.
   always_comb begin
      ltc_d = bus.ltc_wr_req ? (bus.ltc_wr_data + OFS) : (ltc_q + LTC_W'(1));
   end

   // Statistics next values; a same-cycle clear is applied first so the load lands on zero.
   always_comb begin
      load_cnt_d   = bus.stat_clr ? '0 : load_cnt_q;
      slip_cnt_d   = bus.stat_clr ? '0 : slip_cnt_q;
      last_delta_d = bus.stat_clr ? '0 : last_delta_q;
      max_abs_d    = bus.stat_clr ? '0 : max_abs_q;
      sat_d        = bus.stat_clr ? 1'b0 : sat_q;
      if (bus.ltc_wr_req) begin
         if (load_cnt_d != '1) begin
            load_cnt_d = load_cnt_d + CNT_W'(1);
         end
         last_delta_d = '0;
      end
      if (evaluate) begin
         last_delta_d = calc_delta;
         sat_d        = sat_d | calc_sat;
         if (calc_abs > max_abs_d) begin
            max_abs_d = calc_abs;
         end
         if (calc_slip && (slip_cnt_d != '1)) begin
            slip_cnt_d = slip_cnt_d + CNT_W'(1);
         end
      end
   end

   // Lock FSM next state with the good-load and idle (holdover) counters.
   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      idle_d  = idle_q;
      unique case (state_q)
         StUnlocked: begin
            good_d = '0;
            idle_d = '0;
            if (bus.ltc_wr_req) begin
               state_d = StAcquire;
            end
         end
         StAcquire: begin
            if (bus.ltc_wr_req) begin
               idle_d = '0;
               if (calc_slip) begin
                  good_d = '0;
               end else if (good_q + 8'd1 == STABLE_LIM) begin
                  good_d  = '0;
                  state_d = StLocked;
               end else begin
                  good_d = good_q + 8'd1;
               end
            end else if (idle_q == HOLD_LAST) begin
               idle_d  = '0;
               good_d  = '0;
               state_d = StUnlocked;
            end else begin
               idle_d = idle_q + 32'd1;
            end
         end
         StLocked: begin
            if (bus.ltc_wr_req) begin
               idle_d = '0;
               if (calc_slip) begin
                  good_d  = '0;
                  state_d = StAcquire;
               end
            end else if (idle_q == HOLD_LAST) begin
               idle_d  = '0;
               good_d  = '0;
               state_d = StUnlocked;
            end else begin
               idle_d = idle_q + 32'd1;
            end
         end
         default: begin
            state_d = StUnlocked;
            good_d  = '0;
            idle_d  = '0;
         end
      endcase
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StUnlocked;
         good_q       <= '0;
         idle_q       <= '0;
         ltc_q        <= '0;
         load_cnt_q   <= '0;
         slip_cnt_q   <= '0;
         last_delta_q <= '0;
         max_abs_q    <= '0;
         sat_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         good_q       <= good_d;
         idle_q       <= idle_d;
         ltc_q        <= ltc_d;
         load_cnt_q   <= load_cnt_d;
         slip_cnt_q   <= slip_cnt_d;
         last_delta_q <= last_delta_d;
         max_abs_q    <= max_abs_d;
         sat_q        <= sat_d;
      end
   end

   assign bus.ltc           = ltc_q;
   assign bus.load_cnt      = load_cnt_q;
   assign bus.slip_cnt      = slip_cnt_q;
   assign bus.last_delta    = last_delta_q;
   assign bus.max_abs_delta = max_abs_q;
   assign bus.delta_sat     = sat_q;
   assign bus.locked        = (state_q == StLocked);

endmodule
